// File: rtl/watchdog_timer_avs.sv
// Avalon-MM watchdog timer: software/pin-armed down-counter with early-warning IRQ
// and a fixed-length reset_out bite on expiry or on a bad kick key.
module watchdog_timer_avs #(
  parameter logic [31:0] DEFAULT_TIMEOUT = 32'd50000000,
  parameter int unsigned PULSE_LEN       = 16,
  parameter logic [31:0] WARN_CYCLES     = 32'd1000000,
  parameter logic [31:0] KICK_KEY        = 32'h0000A5A5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic        wdt_enable,
  output logic        irq,
  output logic        reset_out
);

  typedef enum logic [1:0] {IDLE, COUNT, BITE} state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);

  state_t      state, state_next;
  logic        en, irq_en;
  logic [31:0] load_reg, count;
  logic        timeout_f, warn_f;
  logic [7:0]  pulse_cnt;

  logic        active;
  logic        wr_ctrl, wr_load, wr_kick, wr_status;
  logic        kick_ok, kick_bad;
  logic        bite_end;
  logic        reload, dec, set_timeout, set_warn;
  logic        timeout_next, warn_next, irq_en_next;
  logic [31:0] rd_mux;

  always_comb begin
    active    = en & wdt_enable;
    wr_ctrl   = avs_write && (avs_address == 2'd0);
    wr_load   = avs_write && (avs_address == 2'd1);
    wr_kick   = avs_write && (avs_address == 2'd2);
    wr_status = avs_write && (avs_address == 2'd3);
    kick_ok   = wr_kick && (avs_writedata == KICK_KEY);
    kick_bad  = wr_kick && (avs_writedata != KICK_KEY);
    bite_end  = (state == BITE) && (pulse_cnt == PULSE_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Losing 'active' takes priority over everything, so a disarm never bites.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (active) state_next = COUNT;
      COUNT: begin
        if (!active)                         state_next = IDLE;
        else if (kick_bad)                   state_next = BITE;
        else if (!kick_ok && count == '0)    state_next = BITE;
      end
      BITE:  if (bite_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reload      = 1'b0;
    dec         = 1'b0;
    set_timeout = 1'b0;
    set_warn    = 1'b0;
    case (state)
      IDLE:  reload = active;
      COUNT: begin
        if (active) begin
          if (kick_ok)             reload      = 1'b1;
          else if (kick_bad)       set_timeout = 1'b1;
          else if (count == '0)    set_timeout = 1'b1;
          else begin
            dec      = 1'b1;
            set_warn = (count == WARN_CYCLES);
          end
        end
      end
      default: ;
    endcase
  end

  // A new event wins over a simultaneous write-1-to-clear.
  always_comb begin
    timeout_next = (timeout_f & ~(wr_status & avs_writedata[0])) | set_timeout;
    warn_next    = (warn_f    & ~(wr_status & avs_writedata[1])) | set_warn;
    irq_en_next  = wr_ctrl ? avs_writedata[1] : irq_en;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux = {30'd0, irq_en, en};
      2'd1: rd_mux = load_reg;
      2'd2: rd_mux = count;
      2'd3: rd_mux = {28'd0, wdt_enable, state == COUNT, warn_f, timeout_f};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en           <= 1'b0;
      irq_en       <= 1'b0;
      load_reg     <= DEFAULT_TIMEOUT;
      count        <= DEFAULT_TIMEOUT;
      timeout_f    <= 1'b0;
      warn_f       <= 1'b0;
      pulse_cnt    <= '0;
      reset_out    <= 1'b0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= avs_writedata[0];
        irq_en <= avs_writedata[1];
      end
      if (bite_end) en <= 1'b0;
      if (wr_load && !en) load_reg <= avs_writedata;
      if (reload)      count <= load_reg;
      else if (dec)    count <= count - 32'd1;
      timeout_f <= timeout_next;
      warn_f    <= warn_next;
      pulse_cnt <= (state == BITE) ? pulse_cnt + 8'd1 : '0;
      reset_out <= (state == BITE);
      irq       <= warn_next & irq_en_next;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule
